// File: rtl/arm_lsu_pkg.sv
// arm_lsu_pkg: shared types, lane helpers and byte-enable generation for arm_lsu
package arm_lsu_pkg;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD} lsu_size_t;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;

    localparam int MAX_LANES     = 8;
    localparam int MAX_LANE_BITS = $clog2(MAX_LANES);

    function automatic int lane_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // 2^size contiguous lanes starting at offset, clipped to the bus width
    function automatic logic [MAX_LANES-1:0] be_gen(input lsu_size_t size,
                                                    input logic [MAX_LANE_BITS-1:0] offset,
                                                    input int nlanes);
        logic [MAX_LANES:0] w;
        w = ((9'd1 << (4'd1 << size)) - 9'd1) << offset;
        return w[MAX_LANES-1:0] & MAX_LANES'((9'd1 << nlanes) - 9'd1);
    endfunction

endpackage

// File: rtl/arm_lsu_lane_extract.sv
// arm_lsu_lane_extract: selects load bytes at the lane offset and zero/sign-extends them
// With ARM_LSU_ROTATE_EN, word loads return the aligned word rotated right by 8*offset[1:0].
module arm_lsu_lane_extract
    import arm_lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = 2
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [OFF_W-1:0]  offset,
    input  lsu_size_t         size,
    input  logic              sgn,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] mask;
    logic [6:0]        nbits;
    logic              sbit;
`ifdef ARM_LSU_ROTATE_EN
    logic [31:0]       wrd;
    logic [31:0]       rot;
`endif

    // Shift the addressed lanes down, mask to the access size and extend from its top bit
    always_comb begin
`ifdef ARM_LSU_ROTATE_EN
        wrd   = 32'(rdata >> {offset & ~OFF_W'(3), 3'b000});
        rot   = 32'({wrd, wrd} >> {offset[1:0], 3'b000});
        sh    = (size == SZ_WORD) ? DATA_W'(rot) : rdata >> {offset, 3'b000};
`else
        sh    = rdata >> {offset, 3'b000};
`endif
        nbits = 7'd8 << size;
        mask  = ~({DATA_W{1'b1}} << nbits);
        sbit  = |(sh & mask & ~(mask >> 1));
        data  = (sh & mask) | ((sgn && sbit) ? ~mask : '0);
    end

endmodule

// File: rtl/arm_lsu.sv
// arm_lsu: multi-cycle load/store unit with valid/ready request, aligned memory bus and timeout
// Optional macro ARM_LSU_ROTATE_EN: misaligned word loads fetch the aligned word and rotate it.
module arm_lsu
    import arm_lsu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = lane_bits(DATA_W);

    lsu_state_t        state, state_nx;
    logic [15:0]       cnt;
    logic              write_q, sgn_q, err_q;
    lsu_size_t         size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q, ext;
    logic              mis, bad, timeout;

    arm_lsu_lane_extract #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_extract (
        .rdata  (mem_rdata),
        .offset (addr_q[OFF_W-1:0]),
        .size   (size_q),
        .sgn    (sgn_q),
        .data   (ext)
    );

    // Legality of the incoming request and the timeout condition of the current access
    always_comb begin
        mis     = (req_addr[2:0] & ((3'd1 << req_size) - 3'd1)) != 3'd0;
`ifdef ARM_LSU_ROTATE_EN
        bad     = (lsu_size_t'(req_size) == SZ_DWORD && DATA_W == 32) ||
                  (mis && (req_write || lsu_size_t'(req_size) != SZ_WORD));
`else
        bad     = (lsu_size_t'(req_size) == SZ_DWORD && DATA_W == 32) || mis;
`endif
        timeout = cnt == 16'(TIMEOUT_CYC - 1);
    end

    // State register; async reset also drops an in-flight access without a response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: illegal requests skip the memory; ack wins over a same-cycle timeout
    always_comb begin
        state_nx = (state == IDLE)   ? (req_valid ? (bad ? RESP : ACCESS) : IDLE) :
                   (state == ACCESS) ? ((mem_ack || timeout) ? RESP : ACCESS) :
                                       IDLE;
    end

    // Request capture, access cycle counter and response data/error registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            write_q <= 1'b0;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else if (state == IDLE && req_valid) begin
            cnt     <= '0;
            write_q <= req_write;
            sgn_q   <= req_signed;
            err_q   <= bad;
            size_q  <= lsu_size_t'(req_size);
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
        end else if (state == ACCESS) begin
            cnt     <= cnt + 16'd1;
            err_q   <= !mem_ack && timeout;
            rdata_q <= (mem_ack && !write_q) ? ext : '0;
        end
    end

    // Outputs: bus signals only while accessing, response only in RESP
    always_comb begin
        req_ready  = state == IDLE;
        mem_req    = state == ACCESS;
        mem_we     = mem_req && write_q;
        mem_addr   = mem_req ? addr_q & ~ADDR_W'(LANES - 1) : '0;
        mem_be     = mem_req ? LANES'(be_gen(size_q,
                                 MAX_LANE_BITS'(addr_q[OFF_W-1:0]) & ~((3'd1 << size_q) - 3'd1),
                                 LANES)) : '0;
        mem_wdata  = !mem_req              ? '0 :
                     (size_q == SZ_BYTE)   ? {LANES{wdata_q[7:0]}} :
                     (size_q == SZ_HALF)   ? {(LANES/2){wdata_q[15:0]}} :
                     (size_q == SZ_WORD)   ? {(LANES/4){wdata_q[31:0]}} :
                                             wdata_q;
        resp_valid = state == RESP;
        resp_err   = resp_valid && err_q;
        resp_rdata = resp_valid ? rdata_q : '0;
    end

endmodule

// File: tb/tb_arm_lsu.sv
// tb_arm_lsu: scoreboard bench for arm_lsu (32-bit instance with short timeout, 64-bit instance)
module tb_arm_lsu;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        b_req_valid = 1'b0, b_req_write = 1'b0, b_req_signed = 1'b0;
    logic [1:0]  b_req_size = 2'd0;
    logic [31:0] b_req_addr = '0;
    logic [63:0] b_req_wdata = '0;
    logic        b_req_ready, b_resp_valid, b_resp_err;
    logic [63:0] b_resp_rdata;
    logic        b_mem_req, b_mem_we;
    logic [31:0] b_mem_addr;
    logic [63:0] b_mem_wdata;
    logic [7:0]  b_mem_be;
    logic        b_mem_ack = 1'b0;
    logic [63:0] b_mem_rdata = '0;

    arm_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    arm_lsu #(.DATA_W(64), .ADDR_W(32), .TIMEOUT_CYC(255)) dut64 (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_size(b_req_size), .req_signed(b_req_signed), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_be(b_mem_be),
        .mem_wdata(b_mem_wdata), .mem_ack(b_mem_ack), .mem_rdata(b_mem_rdata)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse of the 32-bit unit is matched against the scoreboard
    always @(negedge clk) begin
        if (reset && resp_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_resp", 64'd1, 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", resp_err, e.err);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee, input logic push);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        if (push) sbq.push_back('{rdata: er, err: ee});
        step();
        req_valid  = 1'b0;
    endtask

    task automatic ack_after(input string name, input int k, input logic [31:0] rd);
        for (int i = 0; i < k; i++) begin
            chk({name, "_mem_req_wait"}, mem_req, 1'b1);
            step();
        end
        chk({name, "_mem_req_ack"}, mem_req, 1'b1);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        step();
        mem_ack   = 1'b0;
        chk({name, "_resp_valid"}, resp_valid, 1'b1);
        chk({name, "_ready_in_resp"}, req_ready, 1'b0);
        step();
        chk({name, "_ready_after"}, req_ready, 1'b1);
        chk({name, "_resp_drop"}, resp_valid, 1'b0);
    endtask

    task automatic err_now(input string name);
        chk({name, "_no_mem_req"}, mem_req, 1'b0);
        chk({name, "_resp_t1"}, resp_valid, 1'b1);
        step();
        chk({name, "_ready_after"}, req_ready, 1'b1);
    endtask

    task automatic b_access(input string name, input logic w, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rd,
                            input logic [7:0] ebe, input logic [31:0] eaddr, input logic [63:0] ewd,
                            input logic [63:0] erd);
        b_req_valid  = 1'b1;
        b_req_write  = w;
        b_req_size   = sz;
        b_req_signed = sg;
        b_req_addr   = a;
        b_req_wdata  = wd;
        step();
        b_req_valid  = 1'b0;
        chk({name, "_be"}, b_mem_be, ebe);
        chk({name, "_addr"}, b_mem_addr, eaddr);
        chk({name, "_wdata"}, b_mem_wdata, ewd);
        chk({name, "_we"}, b_mem_we, w);
        b_mem_ack   = 1'b1;
        b_mem_rdata = rd;
        step();
        b_mem_ack   = 1'b0;
        chk({name, "_resp_valid"}, b_resp_valid, 1'b1);
        chk({name, "_resp_err"}, b_resp_err, 1'b0);
        chk({name, "_resp_rdata"}, b_resp_rdata, erd);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_be", mem_be, 4'h0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        reset = 1'b1;
        step();

        send(1'b1, 2'd0, 1'b0, 32'h1003, 32'h0000_00AB, 32'h0, 1'b0, 1'b1);
        chk("bst_addr", mem_addr, 32'h1000);
        chk("bst_be", mem_be, 4'b1000);
        chk("bst_wdata", mem_wdata, 32'hABAB_ABAB);
        chk("bst_we", mem_we, 1'b1);
        chk("bst_ready", req_ready, 1'b0);
        ack_after("bst", 2, 32'hFFFF_FFFF);

        send(1'b1, 2'd1, 1'b0, 32'h0002, 32'h0000_1234, 32'h0, 1'b0, 1'b1);
        chk("hst_be", mem_be, 4'b1100);
        chk("hst_wdata", mem_wdata, 32'h1234_1234);
        ack_after("hst", 0, 32'h0);

        send(1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 32'hFFFF_8001, 1'b0, 1'b1);
        chk("shl_be", mem_be, 4'b1100);
        chk("shl_we", mem_we, 1'b0);
        ack_after("shl", 0, 32'h8001_1234);

        send(1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 32'h0000_8001, 1'b0, 1'b1);
        ack_after("uhl", 1, 32'h8001_1234);

        send(1'b0, 2'd0, 1'b1, 32'h5001, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b1);
        chk("sbl_be", mem_be, 4'b0010);
        ack_after("sbl", 1, 32'h0000_8000);

        send(1'b0, 2'd2, 1'b1, 32'h6000, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        chk("wl_be", mem_be, 4'b1111);
        req_valid = 1'b1;
        req_addr  = 32'h9000;
        ack_after("wl", 2, 32'hDEAD_BEEF);
        req_valid = 1'b0;

`ifdef ARM_LSU_ROTATE_EN
        send(1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 32'h1144_3322, 1'b0, 1'b1);
        chk("rot_addr", mem_addr, 32'h3000);
        chk("rot_be", mem_be, 4'b1111);
        ack_after("rot", 0, 32'h4433_2211);
`else
        send(1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 32'h0, 1'b1, 1'b1);
        err_now("misw");
`endif

        send(1'b0, 2'd1, 1'b0, 32'h2001, 32'h0, 32'h0, 1'b1, 1'b1);
        err_now("mish");

        send(1'b1, 2'd2, 1'b0, 32'h3002, 32'h1234_5678, 32'h0, 1'b1, 1'b1);
        err_now("missw");

        send(1'b1, 2'd3, 1'b0, 32'h0010, 32'h0, 32'h0, 1'b1, 1'b1);
        err_now("dw32");

        send(1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("to_mem_req_high", mem_req, 1'b1);
            step();
        end
        chk("to_mem_req_low", mem_req, 1'b0);
        chk("to_resp_valid", resp_valid, 1'b1);
        step();
        chk("to_ready_after", req_ready, 1'b1);

        send(1'b0, 2'd2, 1'b0, 32'h4004, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1);
        ack_after("ack_at_limit", 3, 32'hCAFE_F00D);

        mem_ack = 1'b1;
        step();
        step();
        mem_ack = 1'b0;
        chk("idle_ack_no_resp", resp_valid, 1'b0);
        chk("idle_ack_ready", req_ready, 1'b1);

        send(1'b0, 2'd2, 1'b0, 32'h7000, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("rstmid_mem_req_before", mem_req, 1'b1);
        reset = 1'b0;
        #1;
        chk("rstmid_mem_req_async", mem_req, 1'b0);
        chk("rstmid_ready", req_ready, 1'b1);
        step();
        reset = 1'b1;
        repeat (3) step();
        chk("rstmid_ready_after", req_ready, 1'b1);
        chk("rstmid_no_resp", resp_valid, 1'b0);

        b_access("dst64", 1'b1, 2'd3, 1'b0, 32'h0010, 64'h1122_3344_5566_7788, 64'h0,
                 8'hFF, 32'h0010, 64'h1122_3344_5566_7788, 64'h0);
        b_access("swl64", 1'b0, 2'd2, 1'b1, 32'h000C, 64'h0, 64'h8000_0000_0000_0000,
                 8'hF0, 32'h0008, 64'h0, 64'hFFFF_FFFF_8000_0000);
        b_access("dld64", 1'b0, 2'd3, 1'b1, 32'h0018, 64'h0, 64'hFEDC_BA98_7654_3210,
                 8'hFF, 32'h0018, 64'h0, 64'hFEDC_BA98_7654_3210);

        step();
        chk("sb_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/arm_lsu.md
Name: arm_lsu

Overview:
- Parametrised multi-cycle load/store unit that replaces the single-cycle combinational data-memory path (MemWrite/byteEnable/ReadData) of the ARM core.
- Accepts one load/store request from the core through a valid/ready handshake.
- Drives an aligned memory bus with byte enables and waits for an acknowledge.
- Returns lane-extracted, zero/sign-extended load data or an error response.

Parameters:
- DATA_W, 32, memory bus width; legal values 32 or 64.
- ADDR_W, 32, byte-address width.
- TIMEOUT_CYC, 255, max cycles waiting for mem_ack before error; legal range 1..65535.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = doubleword.
- req_signed  in  1  sign-extend load result.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, illegal size or timeout; qualified by resp_valid.
- mem_req  out  1  memory access request.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  req_addr with the low log2(DATA_W/8) bits cleared.
- mem_be  out  DATA_W/8  byte-lane enables.
- mem_wdata  out  DATA_W  store data replicated/shifted onto lanes.
- mem_ack  in  1  memory completion, single-cycle pulse.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.

Behaviour:
- Reset (reset low, async): state IDLE; all outputs 0 except req_ready = 1; timeout counter 0; captured registers 0.
- FSM states and transitions:
  - IDLE: req_ready = 1. On req_valid, capture write, size, signed, addr and wdata.
    - If misaligned (addr mod 2^size != 0) or size = 3 with DATA_W = 32: go to RESP with err = 1.
    - Otherwise go to ACCESS.
  - ACCESS: mem_req = 1 and mem_we/mem_addr/mem_be/mem_wdata held stable until mem_ack.
    - On mem_ack: capture extracted data; go to RESP with err = 0.
    - If the counter reaches TIMEOUT_CYC without mem_ack: deassert mem_req; go to RESP with err = 1.
  - RESP: resp_valid = 1 for exactly one cycle, then IDLE. The core must accept; there is no backpressure.
- Latency: request accepted at cycle T; mem_req high from T+1; mem_ack at T+1+k (k ≥ 0) gives resp_valid at T+2+k. Error-path latency is resp_valid at T+1.
- req_ready is low in ACCESS and RESP; a request presented then is ignored, not queued.
- mem_ack outside ACCESS is ignored.
- mem_ack in the same cycle the counter hits TIMEOUT_CYC counts as success.
- Byte enables: width 2^size bytes starting at lane addr mod (DATA_W/8).
- Write data: req_wdata low bytes replicated across all lanes.
- Load extraction: select bytes at the lane offset; zero-extend, or sign-extend from the top bit when req_signed. Word and double loads ignore req_signed beyond DATA_W.
- Reset mid-ACCESS: mem_req drops immediately (async); no response is issued.

Optional Feature:
- Macro: ARM_LSU_ROTATE_EN.
- Defined: word loads with addr[1:0] != 0 are not errors. The aligned 32-bit word is fetched (be = 4'b1111 on its lanes) and returned rotated right by 8*addr[1:0], matching ARMv4 LDR semantics. Misaligned stores and halfword loads still error.
- Undefined: all misaligned accesses error with no memory access.

Decomposition:
- arm_lsu_pkg holds:
  - lsu_size_t enum: SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD.
  - lsu_state_t enum: IDLE, ACCESS, RESP.
  - function be_gen(size, offset, nlanes).
  - localparam computing lane-offset bits.
- One sub-module, arm_lsu_lane_extract: combinational lane select, extension and optional rotate, so it can be unit-tested alone.

Test Plan:
- Byte store, DATA_W = 32: addr 0x1003, wdata 0xAB → mem_addr 0x1000, mem_be 4'b1000, mem_wdata 0xABABABAB; ack at k = 2 → resp_valid at T+4, err 0.
- Signed half load: addr 0x2002, mem_rdata 0x8001_1234 → resp_rdata 0xFFFF8001. Unsigned → 0x00008001.
- Misaligned word load at 0x3001, macro undefined → no mem_req; resp_valid at T+1, err 1, rdata 0. Macro defined with rdata 0x44332211 → resp_rdata 0x11443322, err 0.
- Timeout: TIMEOUT_CYC = 4, no mem_ack → mem_req high 4 cycles then low; resp_err 1; req_ready back high the next cycle.
- DATA_W = 64, doubleword store at 0x10 → mem_be 8'hFF. Same request with DATA_W = 32 → err.
- Reset asserted during ACCESS → mem_req 0 in the same cycle, no resp_valid; req_ready 1 after release.
